// File: rtl/ballot_arbiter.sv
// Round-robin arbiter sharing one candidate tally bank between voting booths (grant/read/update/respond).
// Optional VOTE_OVERFLOW_FLAG_EN adds a sticky 'overflow' output for votes lost to saturation.
module ballot_arbiter #(
   parameter int NUM_BOOTHS = 4,
   parameter int NUM_CAND   = 4,
   parameter int CAND_W     = 2,
   parameter int CNT_W      = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         election_open,
   input  logic                         clear,
   input  logic [NUM_BOOTHS-1:0]        booth_req,
   input  logic [NUM_BOOTHS*CAND_W-1:0] booth_cand,
   output logic [NUM_BOOTHS-1:0]        booth_ack,
   output logic [NUM_BOOTHS-1:0]        booth_nak,
   input  logic [CAND_W-1:0]            rd_cand,
   output logic [CNT_W-1:0]             rd_count,
   output logic [CNT_W+CAND_W-1:0]      total_votes,
   output logic                         busy
`ifdef VOTE_OVERFLOW_FLAG_EN
   ,
   output logic                         overflow
`endif
);

   localparam int ID_W  = (NUM_BOOTHS > 1) ? $clog2(NUM_BOOTHS) : 1;
   localparam int TOT_W = CNT_W + CAND_W;
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [TOT_W-1:0]  TOT_MAX    = {TOT_W{1'b1}};
   localparam logic [CAND_W:0]   NUM_CAND_L = (CAND_W+1)'(NUM_CAND);
   localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(NUM_BOOTHS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_GRANT  = 2'd1,
      S_UPDATE = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [TOT_W-1:0] sat_inc_tot(input logic [TOT_W-1:0] v);
      return (v == TOT_MAX) ? v : v + TOT_W'(1);
   endfunction

   state_t                state_r;
   state_t                state_s;
   logic [CNT_W-1:0]      tally_r [NUM_CAND];
   logic [ID_W-1:0]       rr_ptr_r;
   logic [ID_W-1:0]       id_r;
   logic [CAND_W-1:0]     cand_r;
   logic [CNT_W-1:0]      hold_r;
   logic [CNT_W-1:0]      hold_s;
   logic [NUM_BOOTHS-1:0] armed_r;
   logic [NUM_BOOTHS-1:0] armed_s;
   logic [NUM_BOOTHS-1:0] resp_mask_s;
   logic [NUM_BOOTHS-1:0] eligible_s;
   logic                  pick_valid_s;
   logic [ID_W-1:0]       pick_id_s;
   logic [CAND_W-1:0]     pick_cand_s;
   logic                  cand_ok_s;
   logic                  idle_clear_s;

   assign cand_ok_s    = ({1'b0, cand_r} < NUM_CAND_L);
   assign idle_clear_s = (state_r == S_IDLE) && clear;

   // Round-robin pick: descending scan so the lowest offset from rr_ptr wins.
   always_comb begin
      pick_valid_s = 1'b0;
      pick_id_s    = '0;
      pick_cand_s  = '0;
      eligible_s   = booth_req & armed_r & {NUM_BOOTHS{election_open}};
      for (int k = NUM_BOOTHS - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(rr_ptr_r) + k) % NUM_BOOTHS;
         if (eligible_s[idx]) begin
            pick_valid_s = 1'b1;
            pick_id_s    = ID_W'(idx);
            pick_cand_s  = booth_cand[idx*CAND_W +: CAND_W];
         end else begin
            pick_valid_s = pick_valid_s;
         end
      end
   end

   // Tally read muxes; out-of-range ids read as zero.
   always_comb begin
      rd_count = '0;
      hold_s   = '0;
      for (int i = 0; i < NUM_CAND; i++) begin
         if (rd_cand == CAND_W'(i)) rd_count = tally_r[i];
         else                       rd_count = rd_count;
         if (cand_r == CAND_W'(i))  hold_s = tally_r[i];
         else                       hold_s = hold_s;
      end
   end

   // A booth re-arms only after its request is seen low, so a held request counts once.
   always_comb begin
      resp_mask_s = '0;
      if (state_r == S_RESP) resp_mask_s[id_r] = 1'b1;
      else                   resp_mask_s = '0;
      armed_s = (armed_r | ~booth_req) & ~resp_mask_s;
   end

   // FSM next state; clear in IDLE takes priority over any grant.
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (clear)             state_s = S_IDLE;
            else if (pick_valid_s) state_s = S_GRANT;
            else                   state_s = S_IDLE;
         end
         S_GRANT:  state_s = S_UPDATE;
         S_UPDATE: state_s = S_RESP;
         S_RESP:   state_s = S_IDLE;
         default:  state_s = S_IDLE;
      endcase
   end

   // Control registers: state, latched grant, response pulses, pointer and arming.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= S_IDLE;
         busy      <= 1'b0;
         booth_ack <= '0;
         booth_nak <= '0;
         rr_ptr_r  <= '0;
         id_r      <= '0;
         cand_r    <= '0;
         hold_r    <= '0;
         armed_r   <= '1;
      end else begin
         state_r   <= state_s;
         busy      <= (state_s != S_IDLE);
         booth_ack <= '0;
         booth_nak <= '0;
         armed_r   <= armed_s;
         case (state_r)
            S_IDLE: begin
               if (!clear && pick_valid_s) begin
                  id_r   <= pick_id_s;
                  cand_r <= pick_cand_s;
               end
            end
            S_GRANT:  hold_r <= hold_s;
            S_UPDATE: begin
               if (cand_ok_s) booth_ack[id_r] <= 1'b1;
               else           booth_nak[id_r] <= 1'b1;
            end
            S_RESP:   rr_ptr_r <= (id_r == LAST_ID) ? ID_W'(0) : id_r + ID_W'(1);
            default:  ;
         endcase
      end
   end

   // Tally bank and running total; only UPDATE with a valid id writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CAND; i++) tally_r[i] <= '0;
         total_votes <= '0;
      end else if (idle_clear_s) begin
         for (int i = 0; i < NUM_CAND; i++) tally_r[i] <= '0;
         total_votes <= '0;
      end else if ((state_r == S_UPDATE) && cand_ok_s) begin
         for (int i = 0; i < NUM_CAND; i++) begin
            if (cand_r == CAND_W'(i)) tally_r[i] <= sat_inc_cnt(hold_r);
         end
         total_votes <= sat_inc_tot(total_votes);
      end
   end

`ifdef VOTE_OVERFLOW_FLAG_EN
   // Sticky saturation flag, cleared together with the tallies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (idle_clear_s) begin
         overflow <= 1'b0;
      end else if ((state_r == S_UPDATE) && cand_ok_s &&
                   ((hold_r == CNT_MAX) || (total_votes == TOT_MAX))) begin
         overflow <= 1'b1;
      end
   end
`endif

endmodule
